// File: rtl/idle_seq_pkg.sv
`default_nettype none
// ==================================================================================
// idle_seq_pkg -- shared state encoding and constants for idle_frame_sequencer | Rev 1.0
// ==================================================================================
package idle_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    ARMED     = 2'd1,
    RECEIVE   = 2'd2,
    HOLD      = 2'd3
  } seq_state_t;

  localparam logic [3:0] DEFAULT_REF = 4'd13;
  localparam logic [3:0] MIN_REF     = 4'd2;

  function automatic int cnt_width(input int frame_bits);
    return $clog2(frame_bits + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/idle_frame_sequencer_frame_shifter.sv
`default_nettype none
// ==================================================================================
// frame_shifter -- MSB-first bit accumulator with counter and output word register | Rev 1.0
// ==================================================================================
module frame_shifter
  import idle_seq_pkg::*;
#(
  parameter int FRAME_BITS = 24,
  localparam int CNT_W = cnt_width(FRAME_BITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift,
  input  logic                  bit_in,
  input  logic                  clear,
  input  logic                  load,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic [CNT_W-1:0]      bit_cnt,
  output logic                  full
);

  logic [FRAME_BITS-1:0] r_sr;
  logic [FRAME_BITS-1:0] w_sr_next;

  assign w_sr_next = {r_sr[FRAME_BITS-2:0], bit_in};

  // High when the next shifted bit completes the word.
  assign full = (bit_cnt == CNT_W'(FRAME_BITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr       <= '0;
      bit_cnt    <= '0;
      frame_data <= '0;
    end else if (clear) begin
      r_sr    <= '0;
      bit_cnt <= '0;
    end else if (shift) begin
      if (load) begin
        frame_data <= w_sr_next;
        r_sr       <= '0;
        bit_cnt    <= '0;
      end else begin
        r_sr    <= w_sr_next;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/idle_frame_sequencer.sv
`default_nettype none
// ==================================================================================
// idle_frame_sequencer -- brackets LED words between idle gaps, programs idle threshold;
// optional error counter under IDLE_SEQ_ERRCNT_EN | Rev 1.0
// ==================================================================================
module idle_frame_sequencer #(
  parameter int          FRAME_BITS  = 24,
  parameter logic [3:0]  DEFAULT_REF = idle_seq_pkg::DEFAULT_REF,
  parameter logic [3:0]  MIN_REF     = idle_seq_pkg::MIN_REF
) (
  input  logic                  clk,
  input  logic                  globalReset,
  input  logic                  idle_i,
  input  logic                  bit_valid,
  input  logic                  bit_data,
  input  logic                  cfg_req,
  input  logic [3:0]            cfg_ref,
  output logic                  cfg_ack,
  output logic [3:0]            ref_bits,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  short_err,
  output logic                  overrun_err
`ifdef IDLE_SEQ_ERRCNT_EN
  ,
  output logic [7:0]            err_count
`endif
);

  import idle_seq_pkg::*;

  localparam int CNT_W = cnt_width(FRAME_BITS);

  seq_state_t       r_state;
  seq_state_t       w_state_next;
  logic             w_shift;
  logic             w_clear;
  logic             w_load;
  logic             w_short;
  logic             w_overrun;
  logic             w_cfg_service;
  logic [3:0]       w_ref_clamped;
  logic [CNT_W-1:0] w_bit_cnt;
  logic             w_full;

  logic [3:0]       r_ref;
  logic             r_cfg_ack;
  logic             r_frame_valid;
  logic             r_short;
  logic             r_overrun;

  frame_shifter #(
    .FRAME_BITS(FRAME_BITS)
  ) u_shifter (
    .clk       (clk),
    .rst       (globalReset),
    .shift     (w_shift),
    .bit_in    (bit_data),
    .clear     (w_clear),
    .load      (w_load),
    .frame_data(frame_data),
    .bit_cnt   (w_bit_cnt),
    .full      (w_full)
  );

  always_comb begin
    w_state_next = r_state;
    w_shift      = 1'b0;
    w_clear      = 1'b0;
    w_load       = 1'b0;
    w_short      = 1'b0;
    w_overrun    = 1'b0;
    case (r_state)
      WAIT_IDLE: begin
        if (idle_i) w_state_next = ARMED;
      end
      ARMED: begin
        if (bit_valid) begin
          w_shift = 1'b1;
          if (w_full) begin
            w_load       = 1'b1;
            w_state_next = HOLD;
          end else begin
            w_state_next = RECEIVE;
          end
        end
      end
      RECEIVE: begin
        // Idle beats a coincident bit: the frame is already broken.
        if (idle_i) begin
          w_clear      = 1'b1;
          w_short      = (w_bit_cnt < CNT_W'(FRAME_BITS));
          w_state_next = ARMED;
        end else if (bit_valid) begin
          w_shift = 1'b1;
          if (w_full) begin
            w_load       = 1'b1;
            w_state_next = HOLD;
          end
        end
      end
      HOLD: begin
        w_overrun = bit_valid;
        if (frame_ready) w_state_next = WAIT_IDLE;
      end
      default: w_state_next = WAIT_IDLE;
    endcase
  end

  // The ack cycle is skipped so a requester still holding cfg_req is not double-serviced.
  assign w_cfg_service = cfg_req && !r_cfg_ack &&
                         ((r_state == WAIT_IDLE) || (r_state == ARMED));
  assign w_ref_clamped = (cfg_ref < MIN_REF) ? MIN_REF : cfg_ref;

  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      r_state       <= WAIT_IDLE;
      r_ref         <= DEFAULT_REF;
      r_cfg_ack     <= 1'b0;
      r_frame_valid <= 1'b0;
      r_short       <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cfg_ack     <= w_cfg_service;
      r_frame_valid <= (w_state_next == HOLD);
      r_short       <= w_short;
      r_overrun     <= w_overrun;
      if (w_cfg_service) r_ref <= w_ref_clamped;
    end
  end

  assign cfg_ack     = r_cfg_ack;
  assign ref_bits    = r_ref;
  assign frame_valid = r_frame_valid;
  assign short_err   = r_short;
  assign overrun_err = r_overrun;

`ifdef IDLE_SEQ_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      r_err_count <= 8'd0;
    end else if (w_cfg_service) begin
      r_err_count <= 8'd0;
    end else if ((w_short || w_overrun) && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_idle_frame_sequencer.sv
`default_nettype none
// ==================================================================================
// tb_idle_frame_sequencer -- transaction-level scoreboard bench for idle_frame_sequencer | Rev 1.0
// ==================================================================================
module tb_idle_frame_sequencer;

  localparam int FB = 24;

  logic          clk = 1'b0;
  logic          globalReset;
  logic          idle_i;
  logic          bit_valid;
  logic          bit_data;
  logic          cfg_req;
  logic [3:0]    cfg_ref;
  logic          cfg_ack;
  logic [3:0]    ref_bits;
  logic [FB-1:0] frame_data;
  logic          frame_valid;
  logic          frame_ready;
  logic          short_err;
  logic          overrun_err;
`ifdef IDLE_SEQ_ERRCNT_EN
  logic [7:0]    err_count;
`endif

  int tests = 0;
  int fails = 0;

  logic [FB-1:0] exp_frames[$];
  logic [3:0]    exp_cfg[$];
  byte           exp_err[$];

  idle_frame_sequencer #(
    .FRAME_BITS(FB)
  ) dut (
    .clk        (clk),
    .globalReset(globalReset),
    .idle_i     (idle_i),
    .bit_valid  (bit_valid),
    .bit_data   (bit_data),
    .cfg_req    (cfg_req),
    .cfg_ref    (cfg_ref),
    .cfg_ack    (cfg_ack),
    .ref_bits   (ref_bits),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .short_err  (short_err),
    .overrun_err(overrun_err)
`ifdef IDLE_SEQ_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] clamp_ref(input logic [3:0] r);
    return (r < 4'd2) ? 4'd2 : r;
  endfunction

  task automatic send_bit(input logic b, input int gap);
    bit_valid = 1'b0;
    repeat (gap) tick();
    bit_valid = 1'b1;
    bit_data  = b;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic rearm();
    idle_i = 1'b1;
    tick();
    idle_i = 1'b0;
  endtask

  // Entry: ARMED. Exit: ARMED.
  task automatic run_frame(input logic [FB-1:0] data, input int overruns,
                           input bit cfg_mid, input logic [3:0] cref);
    for (int i = FB - 1; i >= 0; i--) begin
      if (cfg_mid && i == FB / 2) begin
        cfg_req = 1'b1;
        cfg_ref = cref;
        exp_cfg.push_back(clamp_ref(cref));
      end
      if (i == 0) exp_frames.push_back(data);
      send_bit(data[i], $urandom_range(0, 2));
    end
    check("frame_valid_latency", frame_valid, 1'b1);
    for (int k = 0; k < overruns; k++) begin
      repeat ($urandom_range(0, 1)) tick();
      exp_err.push_back("O");
      bit_valid = 1'b1;
      bit_data  = 1'($urandom);
      tick();
      bit_valid = 1'b0;
    end
    frame_ready = 1'b1;
    bit_valid   = 1'($urandom_range(0, 1));
    if (bit_valid) exp_err.push_back("O");
    tick();
    frame_ready = 1'b0;
    bit_valid   = 1'b0;
    check("frame_valid_release", frame_valid, 1'b0);
    if (cfg_mid) begin
      tick();
      check("cfg_ack_after_return", cfg_ack, 1'b1);
      cfg_req = 1'b0;
    end
    rearm();
  endtask

  // Entry: ARMED. Exit: ARMED.
  task automatic run_short(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom), $urandom_range(0, 2));
    idle_i    = 1'b1;
    bit_valid = 1'($urandom_range(0, 1));
    exp_err.push_back("S");
    tick();
    idle_i    = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic cfg_armed(input logic [3:0] r);
    cfg_req = 1'b1;
    cfg_ref = r;
    exp_cfg.push_back(clamp_ref(r));
    tick();
    cfg_req = 1'b0;
    check("cfg_ack_pulse", cfg_ack, 1'b1);
    tick();
    check("cfg_ack_single", cfg_ack, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_frame_valid", frame_valid, 1'b0);
    check("rst_frame_data", frame_data, '0);
    check("rst_ref_bits", ref_bits, 4'd13);
    check("rst_cfg_ack", cfg_ack, 1'b0);
    check("rst_short_err", short_err, 1'b0);
    check("rst_overrun_err", overrun_err, 1'b0);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    logic [FB-1:0] held;
    bit            held_v;
    logic [3:0]    prev_ref;
    held_v   = 1'b0;
    prev_ref = 4'd13;
    forever begin
      @(negedge clk);
      if (globalReset !== 1'b0) begin
        prev_ref = ref_bits;
        held_v   = 1'b0;
      end else begin
        if (ref_bits !== prev_ref) check("ref_change_needs_ack", cfg_ack, 1'b1);
        prev_ref = ref_bits;
        if (cfg_ack) begin
          if (exp_cfg.size() == 0) flag_fail("unexpected_cfg_ack");
          else check("cfg_ref_applied", ref_bits, exp_cfg.pop_front());
        end
        if (short_err) begin
          if (exp_err.size() == 0) flag_fail("unexpected_short_err");
          else check("short_err_kind", "S", exp_err.pop_front());
        end
        if (overrun_err) begin
          if (exp_err.size() == 0) flag_fail("unexpected_overrun_err");
          else check("overrun_err_kind", "O", exp_err.pop_front());
        end
        if (frame_valid) begin
          if (held_v) check("frame_data_stable", frame_data, held);
          held   = frame_data;
          held_v = 1'b1;
          if (frame_ready) begin
            if (exp_frames.size() == 0) flag_fail("unexpected_frame");
            else check("frame_data", frame_data, exp_frames.pop_front());
            held_v = 1'b0;
          end
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  initial begin
    globalReset = 1'b1;
    idle_i      = 1'b0;
    bit_valid   = 1'b0;
    bit_data    = 1'b0;
    cfg_req     = 1'b0;
    cfg_ref     = 4'd0;
    frame_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs();
    globalReset = 1'b0;
    tick();
    rearm();

    run_frame(24'hA5C3F0, 0, 1'b0, 4'd0);
    run_short(10);
    run_frame(24'h123456, 0, 1'b0, 4'd0);
    run_frame(24'($urandom), 3, 1'b0, 4'd0);
    run_frame(24'($urandom), 0, 1'b1, 4'd14);
    check("ref_after_mid_cfg", ref_bits, 4'd14);
    cfg_armed(4'd0);
    check("ref_clamped_min", ref_bits, 4'd2);

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: run_frame(24'($urandom), $urandom_range(0, 3), 1'b0, 4'd0);
        1: run_short($urandom_range(1, FB - 1));
        2: cfg_armed(4'($urandom));
        default: run_frame(24'($urandom), $urandom_range(0, 2), 1'b1, 4'($urandom));
      endcase
    end

    // Reset mid-frame with a non-default threshold programmed.
    cfg_armed(4'd5);
    for (int i = 0; i < 7; i++) send_bit(1'($urandom), 0);
    globalReset = 1'b1;
    #2;
    check_reset_outputs();
    tick();
    globalReset = 1'b0;
    tick();
    rearm();
    run_frame(24'h0F1E2D, 0, 1'b0, 4'd0);

`ifdef IDLE_SEQ_ERRCNT_EN
    cfg_armed(4'd9);
    check("errcnt_cleared", err_count, 8'd0);
    for (int i = 0; i < 300; i++) run_short(1);
    tick();
    check("errcnt_saturated", err_count, 8'd255);
    cfg_armed(4'd9);
    check("errcnt_cleared_again", err_count, 8'd0);
`endif

    repeat (3) tick();
    check("pending_frames", exp_frames.size(), 0);
    check("pending_cfg", exp_cfg.size(), 0);
    check("pending_errors", exp_err.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
